// File: rtl/local_hist_update_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : local_hist_update_ctrl
//  Description : Arbiter/controller for a per-set local branch-history
//                shift-register array. Shares the array's single index port
//                between zero-latency prediction lookups and queued
//                branch-resolution updates, owns a PHT of 2-bit saturating
//                counters indexed by history, and sequences a whole-array
//                history clear.
//
//  Ports
//    clk, reset          : clock, asynchronous active-high reset
//    pred_req/pred_index : fetch lookup request and set index
//    pred_ack/pred_taken : lookup accepted this cycle / predicted direction
//    resolve_valid/index/taken, resolve_ready : resolved-branch push port
//    clear_req           : one-cycle pulse requesting a full history clear
//    busy                : FSM not idle or resolve queue non-empty
//    hist_index/load/reset/datain : history array control
//    hist_dataout        : history array read data (combinational from index)
//
//  Revision    : 1.0 - initial release
// ============================================================================
module local_hist_update_ctrl #(
    parameter int S_INDEX    = 3,
    parameter int HIST_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pred_req,
    input  logic [S_INDEX-1:0]    pred_index,
    output logic                  pred_ack,
    output logic                  pred_taken,
    input  logic                  resolve_valid,
    input  logic [S_INDEX-1:0]    resolve_index,
    input  logic                  resolve_taken,
    output logic                  resolve_ready,
    input  logic                  clear_req,
    output logic                  busy,
    output logic [S_INDEX-1:0]    hist_index,
    output logic                  hist_load,
    output logic                  hist_reset,
    output logic                  hist_datain,
    input  logic [HIST_WIDTH-1:0] hist_dataout
);

    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int PHT_SIZE = 2 ** HIST_WIDTH;

    localparam logic [PTR_W:0]     C_FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [S_INDEX-1:0] C_LAST_SET   = '1;
    localparam logic [1:0]         C_PHT_INIT   = 2'b01;
    localparam logic [1:0]         C_PHT_MAX    = 2'b11;
    localparam logic [1:0]         C_PHT_MIN    = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_CLEAR = 2'd3
    } state_t;

    state_t                r_state;
    logic                  r_clear_pend;
    logic [S_INDEX-1:0]    r_sweep;
    logic [HIST_WIDTH-1:0] r_hist_q;

    // Resolve queue
    logic [S_INDEX-1:0]    r_fifo_idx [FIFO_DEPTH];
    logic                  r_fifo_tkn [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W:0]        r_count;

    // Pattern history table
    logic [1:0]            r_pht [PHT_SIZE];

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_pred_active;
    logic [PTR_W:0]        w_count_next;
    logic [S_INDEX-1:0]    w_head_idx;
    logic                  w_head_tkn;
    logic [1:0]            w_pht_old;
    logic [1:0]            w_pht_new;

    assign w_full        = (r_count == C_FULL_COUNT);
    assign w_empty       = (r_count == '0);
    assign w_push        = resolve_valid && !w_full;
    assign w_head_idx    = r_fifo_idx[r_rd_ptr];
    assign w_head_tkn    = r_fifo_tkn[r_rd_ptr];

    // Prediction owns the index port except during a clear sweep. Gating
    // with reset keeps every output at its reset value while reset is held.
    assign w_pred_active = pred_req && (r_state != ST_CLEAR) && !reset;

    // The pop happens in the WRITE cycle, together with the shift and the
    // PHT update, so an entry is never left half-applied.
    assign w_pop         = (r_state == ST_WRITE) && !w_pred_active;

    assign w_count_next  = r_count + {{PTR_W{1'b0}}, w_push}
                                   - {{PTR_W{1'b0}}, w_pop};

    assign resolve_ready = !w_full;
    assign busy          = (r_state != ST_IDLE) || !w_empty;

    // Saturating counter update for the entry selected by captured history
    assign w_pht_old = r_pht[r_hist_q];
    always_comb begin
        w_pht_new = w_pht_old;
        if (w_head_tkn) begin
            if (w_pht_old != C_PHT_MAX) begin
                w_pht_new = w_pht_old + 2'd1;
            end
        end else begin
            if (w_pht_old != C_PHT_MIN) begin
                w_pht_new = w_pht_old - 2'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Queue storage: payload needs no reset, pointers/occupancy do.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_idx[r_wr_ptr] <= resolve_index;
            r_fifo_tkn[r_wr_ptr] <= resolve_taken;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_next;
        end
    end

    // ------------------------------------------------------------------
    // PHT: only reset initialises it; a history clear leaves it intact.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PHT_SIZE; i++) begin
                r_pht[i] <= C_PHT_INIT;
            end
        end else if (w_pop) begin
            r_pht[r_hist_q] <= w_pht_new;
        end
    end

    // ------------------------------------------------------------------
    // Update FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_clear_pend <= 1'b0;
            r_sweep      <= '0;
            r_hist_q     <= '0;
        end else begin
            // Requests seen during a sweep are absorbed by that sweep.
            if (clear_req && (r_state != ST_CLEAR)) begin
                r_clear_pend <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (!w_pred_active) begin
                        if (r_clear_pend) begin
                            r_state <= ST_CLEAR;
                        end else if (!w_empty) begin
                            r_state <= ST_READ;
                        end
                    end
                end

                ST_READ: begin
                    if (!w_pred_active) begin
                        r_hist_q <= hist_dataout;
                        r_state  <= ST_WRITE;
                    end
                end

                ST_WRITE: begin
                    if (!w_pred_active) begin
                        if (r_clear_pend) begin
                            r_state <= ST_CLEAR;
                        end else if (w_count_next != '0) begin
                            r_state <= ST_READ;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end

                ST_CLEAR: begin
                    if (r_sweep == C_LAST_SET) begin
                        r_sweep      <= '0;
                        r_clear_pend <= 1'b0;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_sweep <= r_sweep + 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Array port and prediction outputs. Prediction is combinational so
    // it completes in the same cycle as the request.
    // ------------------------------------------------------------------
    always_comb begin
        pred_ack    = 1'b0;
        pred_taken  = 1'b0;
        hist_index  = '0;
        hist_load   = 1'b0;
        hist_reset  = 1'b0;
        hist_datain = 1'b0;

        if (w_pred_active) begin
            pred_ack   = 1'b1;
            hist_index = pred_index;
            pred_taken = r_pht[hist_dataout][1];
        end else begin
            case (r_state)
                ST_READ: begin
                    hist_index = w_head_idx;
                end
                ST_WRITE: begin
                    hist_index  = w_head_idx;
                    hist_load   = 1'b1;
                    hist_datain = w_head_tkn;
                end
                ST_CLEAR: begin
                    hist_index = r_sweep;
                    hist_reset = 1'b1;
                end
                default: begin
                    hist_index = '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_local_hist_update_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_local_hist_update_ctrl
//  Description : Directed self-checking bench for local_hist_update_ctrl.
//                Includes a behavioural model of the external history
//                shift-register array; a mask on its read data lets a test
//                pin every lookup onto one PHT entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_local_hist_update_ctrl;

    logic       clk;
    logic       reset;
    logic       pred_req;
    logic [2:0] pred_index;
    logic       pred_ack;
    logic       pred_taken;
    logic       resolve_valid;
    logic [2:0] resolve_index;
    logic       resolve_taken;
    logic       resolve_ready;
    logic       clear_req;
    logic       busy;
    logic [2:0] hist_index;
    logic       hist_load;
    logic       hist_reset;
    logic       hist_datain;
    logic [7:0] hist_dataout;

    logic [7:0] r_arr [8];
    logic [7:0] hist_mask;

    int n_checks = 0;
    int n_fail   = 0;

    local_hist_update_ctrl #(
        .S_INDEX    (3),
        .HIST_WIDTH (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pred_req      (pred_req),
        .pred_index    (pred_index),
        .pred_ack      (pred_ack),
        .pred_taken    (pred_taken),
        .resolve_valid (resolve_valid),
        .resolve_index (resolve_index),
        .resolve_taken (resolve_taken),
        .resolve_ready (resolve_ready),
        .clear_req     (clear_req),
        .busy          (busy),
        .hist_index    (hist_index),
        .hist_load     (hist_load),
        .hist_reset    (hist_reset),
        .hist_datain   (hist_datain),
        .hist_dataout  (hist_dataout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // History array model
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) r_arr[i] <= 8'h00;
        end else if (hist_load) begin
            r_arr[hist_index] <= {r_arr[hist_index][6:0], hist_datain};
        end else if (hist_reset) begin
            r_arr[hist_index] <= 8'h00;
        end
    end
    assign hist_dataout = r_arr[hist_index] & hist_mask;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        pred_req      = 1'b0;
        pred_index    = 3'd0;
        resolve_valid = 1'b0;
        resolve_index = 3'd0;
        resolve_taken = 1'b0;
        clear_req     = 1'b0;
        hist_mask     = 8'hFF;
        @(posedge clk);
        #3;
        reset = 1'b0;
    endtask

    // Bound on total run time
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    logic sat_tkn [10];
    logic sat_exp [10];

    initial begin
        // ---------------- reset values ----------------
        reset = 1'b1; pred_req = 1'b0; pred_index = 3'd0;
        resolve_valid = 1'b0; resolve_index = 3'd0; resolve_taken = 1'b0;
        clear_req = 1'b0; hist_mask = 8'hFF;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_pred_ack",   32'(pred_ack),      32'd0);
        chk("rst_pred_taken", 32'(pred_taken),    32'd0);
        chk("rst_load",       32'(hist_load),     32'd0);
        chk("rst_hreset",     32'(hist_reset),    32'd0);
        chk("rst_index",      32'(hist_index),    32'd0);
        chk("rst_datain",     32'(hist_datain),   32'd0);
        chk("rst_ready",      32'(resolve_ready), 32'd1);
        chk("rst_busy",       32'(busy),          32'd0);
        reset = 1'b0;

        // ---------------- basic update ----------------
        tick();
        resolve_valid = 1'b1; resolve_index = 3'd2; resolve_taken = 1'b1;
        #1 chk("basic_ready", 32'(resolve_ready), 32'd1);
        tick();
        resolve_valid = 1'b0;
        #1 chk("basic_idle_load", 32'(hist_load), 32'd0);
        chk("basic_busy", 32'(busy), 32'd1);
        tick();
        #1 chk("basic_read_load", 32'(hist_load), 32'd0);
        chk("basic_read_idx", 32'(hist_index), 32'd2);
        tick();
        #1 chk("basic_wr_load", 32'(hist_load), 32'd1);
        chk("basic_wr_idx", 32'(hist_index), 32'd2);
        chk("basic_wr_din", 32'(hist_datain), 32'd1);
        tick();
        pred_req = 1'b1; pred_index = 3'd2;
        #1 chk("basic_pred_ack", 32'(pred_ack), 32'd1);
        chk("basic_pred_idx2", 32'(pred_taken), 32'd0);
        pred_index = 3'd0;
        #1 chk("basic_pht0_taken", 32'(pred_taken), 32'd1);
        pred_req = 1'b0;
        #1 chk("basic_done_busy", 32'(busy), 32'd0);

        // ---------------- arbitration ----------------
        do_reset();
        tick();
        resolve_valid = 1'b1; resolve_index = 3'd5; resolve_taken = 1'b0;
        tick();
        resolve_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pred_req = 1'b1; pred_index = 3'd3;
            #1 chk("arb_ack", 32'(pred_ack), 32'd1);
            chk("arb_noload", 32'(hist_load), 32'd0);
            tick();
        end
        pred_req = 1'b0;
        #1 chk("arb_drop_load", 32'(hist_load), 32'd0);
        tick();
        #1 chk("arb_read_load", 32'(hist_load), 32'd0);
        chk("arb_read_idx", 32'(hist_index), 32'd5);
        tick();
        #1 chk("arb_wr_load", 32'(hist_load), 32'd1);
        chk("arb_wr_idx", 32'(hist_index), 32'd5);
        chk("arb_wr_din", 32'(hist_datain), 32'd0);

        // ---------------- saturation ----------------
        sat_tkn = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        sat_exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        do_reset();
        hist_mask = 8'h00;
        for (int i = 0; i < 10; i++) begin
            tick();
            resolve_valid = 1'b1; resolve_index = 3'd0; resolve_taken = sat_tkn[i];
            tick();
            resolve_valid = 1'b0;
            tick();
            tick();
            tick();
            pred_req = 1'b1; pred_index = 3'd0;
            #1 chk($sformatf("sat_step%0d", i), 32'(pred_taken), 32'(sat_exp[i]));
            pred_req = 1'b0;
        end

        // ---------------- full queue ----------------
        do_reset();
        tick();
        pred_req = 1'b1; pred_index = 3'd0;
        for (int i = 0; i < 4; i++) begin
            resolve_valid = 1'b1; resolve_index = 3'(i); resolve_taken = 1'b1;
            #1 chk($sformatf("full_ready%0d", i), 32'(resolve_ready), 32'd1);
            tick();
        end
        resolve_valid = 1'b1; resolve_index = 3'd7;
        #1 chk("full_ready_low", 32'(resolve_ready), 32'd0);
        tick();
        resolve_valid = 1'b0; pred_req = 1'b0;
        #1 chk("full_ready_hold", 32'(resolve_ready), 32'd0);
        tick();
        tick();
        #1 chk("full_wr0_load", 32'(hist_load), 32'd1);
        chk("full_wr0_idx", 32'(hist_index), 32'd0);
        chk("full_ready_at_pop", 32'(resolve_ready), 32'd0);
        tick();
        #1 chk("full_ready_back", 32'(resolve_ready), 32'd1);
        for (int j = 1; j < 4; j++) begin
            tick();
            #1 chk($sformatf("full_wr%0d_load", j), 32'(hist_load), 32'd1);
            chk($sformatf("full_wr%0d_idx", j), 32'(hist_index), 32'(j));
            tick();
        end
        #1 chk("full_drained_busy", 32'(busy), 32'd0);

        // ---------------- clear during update ----------------
        do_reset();
        tick();
        resolve_valid = 1'b1; resolve_index = 3'd3; resolve_taken = 1'b1;
        tick();
        resolve_valid = 1'b0;
        tick();
        clear_req = 1'b1;
        #1 chk("clr_read_idx", 32'(hist_index), 32'd3);
        chk("clr_read_load", 32'(hist_load), 32'd0);
        tick();
        clear_req = 1'b0;
        #1 chk("clr_wr_load", 32'(hist_load), 32'd1);
        chk("clr_wr_idx", 32'(hist_index), 32'd3);
        chk("clr_wr_noreset", 32'(hist_reset), 32'd0);
        tick();
        pred_req = 1'b1; pred_index = 3'd3;
        for (int i = 0; i < 8; i++) begin
            resolve_valid = (i == 0);
            resolve_index = 3'd6; resolve_taken = 1'b1;
            clear_req = (i == 4);
            #1 chk($sformatf("clr_sweep%0d_reset", i), 32'(hist_reset), 32'd1);
            chk($sformatf("clr_sweep%0d_idx", i), 32'(hist_index), 32'(i));
            chk($sformatf("clr_sweep%0d_ack", i), 32'(pred_ack), 32'd0);
            chk($sformatf("clr_sweep%0d_load", i), 32'(hist_load), 32'd0);
            tick();
        end
        resolve_valid = 1'b0; clear_req = 1'b0; pred_req = 1'b0;
        #1 chk("clr_end_reset", 32'(hist_reset), 32'd0);
        chk("clr_end_busy", 32'(busy), 32'd1);
        tick();
        #1 chk("clr_post_read_reset", 32'(hist_reset), 32'd0);
        chk("clr_post_read_idx", 32'(hist_index), 32'd6);
        tick();
        #1 chk("clr_post_wr_load", 32'(hist_load), 32'd1);
        chk("clr_post_wr_idx", 32'(hist_index), 32'd6);
        chk("clr_post_wr_din", 32'(hist_datain), 32'd1);
        tick();
        pred_req = 1'b1; pred_index = 3'd3;
        #1 chk("clr_pred_set3", 32'(pred_taken), 32'd1);
        pred_index = 3'd6;
        #1 chk("clr_pred_set6", 32'(pred_taken), 32'd0);
        pred_req = 1'b0;

        // ---------------- mid-operation reset ----------------
        do_reset();
        tick();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        resolve_valid = 1'b1; resolve_index = 3'd1; resolve_taken = 1'b1;
        tick();
        resolve_valid = 1'b0;
        tick();
        tick();
        #1 chk("mrst_sweep_reset", 32'(hist_reset), 32'd1);
        chk("mrst_sweep_idx", 32'(hist_index), 32'd2);
        chk("mrst_sweep_busy", 32'(busy), 32'd1);
        #1 reset = 1'b1;
        #1 chk("mrst_hreset", 32'(hist_reset), 32'd0);
        chk("mrst_idx", 32'(hist_index), 32'd0);
        chk("mrst_load", 32'(hist_load), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_ready", 32'(resolve_ready), 32'd1);
        chk("mrst_ack", 32'(pred_ack), 32'd0);
        chk("mrst_taken", 32'(pred_taken), 32'd0);
        #2 reset = 1'b0;
        tick();
        #1 chk("mrst_after_busy", 32'(busy), 32'd0);
        chk("mrst_after_hreset", 32'(hist_reset), 32'd0);
        tick();
        #1 chk("mrst_after2_busy", 32'(busy), 32'd0);
        chk("mrst_after2_load", 32'(hist_load), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/local_hist_update_ctrl.md
# local_hist_update_ctrl

Controller and arbiter for the per-set local branch-history shift-register array (clk/reset/load/index/datain/dataout, `num_sets` entries). It owns the array's single index port and shares it between same-cycle prediction lookups from fetch and queued branch-resolution updates from execute. It also owns a pattern history table (PHT) of 2-bit saturating counters indexed by history, and it sequences a whole-array history clear.

## Interface
- `s_index`, 3, set-index width; `num_sets` = 2**`s_index`.
- `hist_width`, 8, history bits used to index the PHT; must be ≤ array data width.
- `fifo_depth`, 4, pending-resolve queue depth; must be a power of 2 and ≥ 2.
- `clk` input 1, the single clock.
- `reset` input 1, asynchronous, active-high.
- `pred_req` input 1, fetch requests a prediction this cycle.
- `pred_index` input `s_index`, set to look up.
- `pred_ack` output 1, prediction is valid this cycle.
- `pred_taken` output 1, predicted direction.
- `resolve_valid` input 1, execute offers a resolved branch.
- `resolve_index` input `s_index`, set of the resolved branch.
- `resolve_taken` input 1, actual direction.
- `resolve_ready` output 1, queue can accept; a push occurs when valid && ready.
- `clear_req` input 1, one-cycle pulse requesting a full history clear.
- `busy` output 1, high in any state other than IDLE or while the queue is non-empty.
- `hist_index` output `s_index`, drives the array index.
- `hist_load` output 1, array shift-in enable.
- `hist_reset` output 1, array entry clear.
- `hist_datain` output 1, bit shifted into history.
- `hist_dataout` input `hist_width`, array read data, combinational from `hist_index`.

## Operation
- **Queue:** FIFO of {index, taken}. `resolve_ready` = !full, derived from registered occupancy. When the queue is full, a same-cycle pop does not admit a push.
- **Prediction path (highest priority):** when `pred_req`=1 and state≠CLEAR:
  - `hist_index` = `pred_index`, `pred_ack` = 1.
  - `pred_taken` = PHT[`hist_dataout`][1].
  - The update FSM holds its state for that cycle.
- **Update FSM:** states IDLE, READ, WRITE, CLEAR.
  - IDLE: goes to CLEAR if a clear is pending. Otherwise goes to READ if the queue is non-empty. Otherwise stays in IDLE.
  - READ: if not pre-empted, drives `hist_index` = head.index and captures `hist_dataout` into `hist_q`, then goes to WRITE.
  - WRITE: if not pre-empted, does all of the following in one cycle:
    - drives `hist_index` = head.index, `hist_load` = 1, `hist_datain` = head.taken;
    - PHT[`hist_q`] increments if taken, decrements if not taken, saturating at 3 and 0;
    - pops the queue.
  - From WRITE: goes to CLEAR if a clear is pending, else to READ if the queue is still non-empty, else to IDLE.
  - CLEAR: a `s_index`-bit counter sweeps 0..`num_sets`-1, one set per cycle. Each cycle drives `hist_index` = counter and `hist_reset` = 1. After the final set, the FSM goes to IDLE and the pending flag drops.
  - Prediction does not pre-empt CLEAR. `pred_ack` = 0 throughout CLEAR, and `pred_taken` = 0.
- **Clear requests:** `clear_req` sets a sticky pending flag. A request arriving during READ is served after the in-flight WRITE completes, so an entry is never split. A request arriving during CLEAR is absorbed, and the sweep does not restart.
- **Queue during CLEAR:** the queue keeps accepting resolves. They are applied after the clear, on top of the zeroed history.
- **PHT:** the PHT is not cleared by `clear_req`. Only `reset` initialises it.
- **Idle outputs:** with no prediction and the FSM in IDLE, `hist_index` = 0, `hist_load` = 0, `hist_reset` = 0, `hist_datain` = 0.
- **Exclusivity:** `hist_load` and `hist_reset` are never both 1.

## Timing
- Reset values:
  - state = IDLE, queue empty, `resolve_ready` = 1, `busy` = 0;
  - `pred_ack` = 0, `pred_taken` = 0;
  - `hist_load` = 0, `hist_reset` = 0, `hist_index` = 0, `hist_datain` = 0;
  - clear-pending flag = 0, sweep counter = 0;
  - all PHT entries = 01 (weakly not-taken).
- Reset asserted mid-operation returns everything to these values immediately. Partially applied updates are discarded.
- Prediction latency: 0 cycles (combinational from `pred_req`/`pred_index` through `hist_dataout`).
- Update latency: a push at edge N gives READ at cycle N+1 and the WRITE (history shift + PHT update) at edge N+2, provided the FSM was IDLE and there are no predictions. Each predicted cycle adds one cycle of delay.
- Sustained update throughput: one entry per 2 cycles.
- Clear: occupies exactly `num_sets` cycles once entered.
- A prediction in the cycle after a WRITE sees the updated history and counter.

## Test plan
- **Basic update:** after reset, push {index 2, taken 1} and hold `pred_req`=0. Required: `hist_load`=1 with `hist_index`=2 and `hist_datain`=1 exactly 2 cycles later, and PHT[0] moves 01→10. A following `pred_req` at index 2 (history 0x01) gives `pred_taken`=0, since PHT[1]=01.
- **Arbitration:** hold `pred_req`=1 for 5 cycles while 1 entry is queued. Required: `pred_ack`=1 every cycle, no `hist_load`, and the WRITE lands 2 cycles after `pred_req` drops.
- **Saturation:** 4 taken resolves to set 0 with history masked to the same PHT entry → counter saturates at 3. Then 5 not-taken → counter saturates at 0, never wrapping.
- **Full queue:** push 4 entries back-to-back with the FSM held by `pred_req`. Required: `resolve_ready`=0 after the 4th push, a 5th valid is not accepted, and ready returns 1 the cycle after the first pop.
- **Clear during update:** pulse `clear_req` in READ. Required: the WRITE completes, then 8 cycles of `hist_reset`=1 with `hist_index` 0..7 while `pred_ack`=0, and a resolve pushed during CLEAR is applied afterward.
- **Mid-operation reset:** assert `reset` mid-sweep. Required: all outputs return to reset values asynchronously, and after release the queue is empty and `busy`=0.
